// File: rtl/data_memory_pkg.sv
// data_memory_pkg: shared constants and word/byte-enable types for the
// rv32i data memory and its byte-merge helper.
package data_memory_pkg;

  localparam int DM_DATA_W = 32;
  localparam int DM_ADDR_W = 16;
  localparam int DM_BYTES  = 4;

  typedef logic [DM_DATA_W-1:0] dm_word_t;
  typedef logic [DM_BYTES-1:0]  dm_be_t;

endpackage

// File: rtl/data_memory_byte_merge.sv
// dm_byte_merge: combinational byte-lane merge of a write word into the
// currently stored word. Only meaningful (and only compiled) when the
// DATA_MEM_BYTE_EN build option is defined.
`ifdef DATA_MEM_BYTE_EN
module dm_byte_merge
  import data_memory_pkg::*;
(
  input  dm_word_t old_word,
  input  dm_word_t wd,
  input  dm_be_t   be,
  output dm_word_t merged
);

  // Take each byte lane from wd where its enable is set, else keep the old byte.
  always_comb begin
    merged = old_word;
    for (int i = 0; i < DM_BYTES; i++) begin
      if (be[i]) merged[8*i +: 8] = wd[8*i +: 8];
    end
  end

endmodule
`endif

// File: rtl/data_memory.sv
// data_memory: word-addressed data memory for the rv32i memory stage.
// One combinational read port and one synchronous write port share addr.
// Every word clears asynchronously while rst_n is low. Out-of-range
// addresses (addr >= DEPTH) read as zero and drop writes; no wrap-around.
// Build option DATA_MEM_BYTE_EN adds the be[3:0] port and byte-masked writes.
module data_memory
  import data_memory_pkg::*;
#(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = DM_ADDR_W,
  parameter int DATA_W = DM_DATA_W
)
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wd,
`ifdef DATA_MEM_BYTE_EN
  input  logic [DM_BYTES-1:0] be,
`endif
  output logic [DATA_W-1:0] rd
);

  localparam int          IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] DEPTH_U = 32'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic              in_range;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] word_old;
  logic [DATA_W-1:0] word_new;

  // Full-width compare so out-of-range addresses never alias onto low words.
  assign in_range = (32'(addr) < DEPTH_U);
  assign idx      = addr[IDX_W-1:0];
  assign word_old = mem[idx];

`ifdef DATA_MEM_BYTE_EN
  dm_byte_merge u_byte_merge (
    .old_word (word_old),
    .wd       (wd),
    .be       (be),
    .merged   (word_new)
  );
`else
  assign word_new = wd;
`endif

  // Read is purely combinational; out-of-range reads return zero.
  assign rd = in_range ? word_old : '0;

  // Storage: async clear on reset, single-word write on the rising edge.
  // A non-1 we (including X) falls through to "no write".
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we && in_range) begin
      mem[idx] <= word_new;
    end
  end

endmodule

// File: tb/tb_data_memory.sv
module tb_data_memory;

  localparam int DEPTH = 64;

  logic        clk;
  logic        rst_n;
  logic        we;
  logic [15:0] addr;
  logic [31:0] wd;
  logic [3:0]  be;
  logic [31:0] rd;

  int n_pass;
  int n_total;

  // Reference contents, indexed by word address.
  logic [31:0] ref_mem [DEPTH];

  data_memory #(.DEPTH(DEPTH), .ADDR_W(16), .DATA_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (we),
    .addr  (addr),
    .wd    (wd),
`ifdef DATA_MEM_BYTE_EN
    .be    (be),
`endif
    .rd    (rd)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d done", n_pass, n_total);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [31:0] model_rd(input logic [15:0] a);
    if (int'(a) < DEPTH) return ref_mem[int'(a)];
    return 32'h0;
  endfunction

  task automatic model_write(input logic w, input logic [15:0] a, input logic [31:0] d,
                             input logic [3:0] b);
    logic [31:0] mask;
    if (w !== 1'b1 || int'(a) >= DEPTH) return;
    mask = {{8{b[3]}}, {8{b[2]}}, {8{b[1]}}, {8{b[0]}}};
    ref_mem[int'(a)] = (ref_mem[int'(a)] & ~mask) | (d & mask);
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'h0;
  endtask

  // Drive inputs (just after an edge), then wait through the next rising edge.
  task automatic do_cycle(input logic w, input logic [15:0] a, input logic [31:0] d,
                          input logic [3:0] b);
    we = w; addr = a; wd = d; be = b;
    @(posedge clk);
    model_write(w, a, d, b);
    #1;
  endtask

  task automatic sweep(input string name);
    we = 1'b0;
    for (int a = 0; a < 32; a++) begin
      addr = 16'(a);
      #1;
      check(name, rd, model_rd(16'(a)));
    end
  endtask

  typedef struct {
    logic        w;
    logic [15:0] a;
    logic [31:0] d;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs [10];

  initial begin
    logic [15:0] ra, probe;
    logic [31:0] rdat;
    logic [3:0]  rbe;
    logic        rw;

    n_pass = 0; n_total = 0;
    vecs[0] = '{1'b1, 16'd10, 32'h0000_0012, 32'h0000_0012};
    vecs[1] = '{1'b1, 16'd5,  32'h0000_F00F, 32'h0000_F00F};
    vecs[2] = '{1'b1, 16'd21, 32'h0000_0ABC, 32'h0000_0ABC};
    vecs[3] = '{1'b0, 16'd10, 32'hDEAD_BEEF, 32'h0000_0012};
    vecs[4] = '{1'b0, 16'd10, 32'hDEAD_BEEF, 32'h0000_0012};
    vecs[5] = '{1'b0, 16'd10, 32'hDEAD_BEEF, 32'h0000_0012};
    vecs[6] = '{1'b1, 16'd10, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
    vecs[7] = '{1'b1, 16'd64, 32'h55AA_55AA, 32'h0000_0000};
    vecs[8] = '{1'b0, 16'd0,  32'h0000_0000, 32'h0000_0000};
    vecs[9] = '{1'b1, 16'd63, 32'hCAFE_F00D, 32'hCAFE_F00D};

    // Reset with nonzero inputs; nothing may be written while held.
    rst_n = 1'b0; we = 1'b1; addr = 16'd3; wd = 32'hFFFF_FFFF; be = 4'hF;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    check("rd_during_reset", rd, 32'h0);
    @(negedge clk);
    rst_n = 1'b1; we = 1'b0;
    @(posedge clk); #1;
    sweep("reset_sweep");

    // Directed table: each vector is applied for one edge, then rd checked.
    for (int i = 0; i < 10; i++) begin
      do_cycle(vecs[i].w, vecs[i].a, vecs[i].d, 4'hF);
      check($sformatf("vec%0d", i), rd, vecs[i].exp_rd);
      if (i == 2) sweep("post_write_sweep");
    end
    we = 1'b0; addr = 16'd0; #1;
    check("no_wrap_addr0", rd, 32'h0);
    addr = 16'd65535; #1;
    check("rd_addr_max_zero", rd, 32'h0);

    // Read-during-write: old word before the edge, new word after it.
    we = 1'b1; addr = 16'd7; wd = 32'h1357_9BDF; be = 4'hF; #1;
    check("rdw_before_edge", rd, 32'h0);
    @(posedge clk); model_write(1'b1, 16'd7, 32'h1357_9BDF, 4'hF); #1;
    check("rdw_after_edge", rd, 32'h1357_9BDF);

`ifdef DATA_MEM_BYTE_EN
    do_cycle(1'b1, 16'd3, 32'h1122_3344, 4'hF);
    check("be_full", rd, 32'h1122_3344);
    do_cycle(1'b1, 16'd3, 32'hAABB_CCDD, 4'b0001);
    check("be_0001", rd, 32'h1122_33DD);
    do_cycle(1'b1, 16'd3, 32'hAABB_CCDD, 4'b1010);
    check("be_1010", rd, 32'hAA22_CCDD);
    do_cycle(1'b1, 16'd3, 32'h0000_0000, 4'b0000);
    check("be_0000", rd, 32'hAA22_CCDD);
`endif

    // Async reset between edges: rd must clear before the next edge.
    we = 1'b0; addr = 16'd5; #1;
    check("pre_reset_addr5", rd, 32'h0000_F00F);
    rst_n = 1'b0; model_clear(); #1;
    check("async_rst_addr5", rd, 32'h0);
    addr = 16'd10; #1;
    check("async_rst_addr10", rd, 32'h0);
    addr = 16'd21; #1;
    check("async_rst_addr21", rd, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    sweep("post_reset_sweep");

    // Randomized traffic against the reference array.
    for (int it = 0; it < 400; it++) begin
      rw   = 1'($urandom_range(0, 1));
      ra   = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 79)) : 16'($urandom_range(0, 15));
      rdat = $urandom;
`ifdef DATA_MEM_BYTE_EN
      rbe  = 4'($urandom);
`else
      rbe  = 4'hF;
`endif
      we = rw; addr = ra; wd = rdat; be = rbe; #1;
      check("rand_before_edge", rd, model_rd(ra));
      @(posedge clk);
      model_write(rw, ra, rdat, rbe);
      #1;
      check("rand_after_edge", rd, model_rd(ra));
      probe = 16'($urandom_range(0, 70));
      we = 1'b0; addr = probe; #1;
      check("rand_probe", rd, model_rd(probe));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/data_memory.md
# data_memory

Word-addressed data memory for the rv32i core, sitting on the load/store path of the datapath's memory stage. It provides one combinational read port and one synchronous write port sharing a single address. Contents clear asynchronously on reset. A compile-time option adds per-byte write enables.

## Interface
Parameters:
- `DEPTH`, default 64: number of 32-bit words stored; legal values are powers of two from 2 to 65536.
- `ADDR_W`, default 16: address port width.
- `DATA_W`, default 32: word width; fixed at 32.

Ports:
- `clk`  input  1  system clock; all writes occur on its rising edge.
- `rst_n`  input  1  reset, asynchronous, active-low; clears every word.
- `we`  input  1  write enable, sampled at the rising edge of `clk`.
- `addr`  input  16  word address for both read and write; not a byte address.
- `wd`  input  32  write data.
- `be`  input  4  byte enables; bit i covers `wd[8i+7:8i]`. Present only with `DATA_MEM_BYTE_EN`.
- `rd`  output  32  read data; combinational from `addr` and current contents.

## Operation
- Storage: `DEPTH` words of 32 bits, indexed by `addr`.
- In range means `addr < DEPTH`.
- Read:
  - In range: `rd` = the stored word at `addr`.
  - Out of range: `rd` = 0.
  - No read enable.
- Write, at a rising edge of `clk` with `rst_n`=1, `we`=1 and `addr` in range:
  - Without `DATA_MEM_BYTE_EN`: the word at `addr` ← `wd`.
  - With `DATA_MEM_BYTE_EN`: only the bytes with `be[i]`=1 are written; the other bytes keep their value.
  - Writes to out-of-range addresses are dropped; no aliasing or wrap-around.
- `we`=0: contents are unchanged regardless of `wd`, `addr` or `be`.
- Reset:
  - `rst_n`=0 immediately clears every word to 0, independent of `clk`.
  - While reset is held, `rd` reads 0 and writes are ignored.
  - Reset asserted mid-sequence discards all prior writes.
- X/Z on `we` must not corrupt contents; treat non-1 as no write.

## Timing
- Read latency is 0 cycles: `rd` follows `addr` and contents combinationally.
- Write takes effect at the rising edge; `rd` at the same address shows the new value after that edge, in the same cycle.
- Read-during-write at the same address: `rd` shows the old word before the edge and the new word after it.
- Reset:
  - Assertion clears the array asynchronously.
  - Deassertion is synchronous-safe: the first write can occur at the first rising edge with `rst_n`=1.
  - A write coincident with reset deassertion is allowed to take effect.
- Reset value of `rd` is 0.

## Configuration
- Macro `DATA_MEM_BYTE_EN`.
  - Defined: the `be[3:0]` port exists and writes are byte-masked.
  - Undefined: the `be` port is absent and every write replaces the whole word.
- Behaviour with `be`=4'b1111 is identical to the undefined build.

## Structure
- Shared package `data_memory_pkg` holds:
  - constants `DM_DATA_W`=32, `DM_ADDR_W`=16, `DM_BYTES`=4;
  - typedef `dm_word_t` (logic [31:0]);
  - typedef `dm_be_t` (logic [3:0]).
- One sub-module is natural: `dm_byte_merge`.
  - Combinational.
  - Inputs are the old word, `wd` and `be`; the output is the merged word.
  - Instantiated only when `DATA_MEM_BYTE_EN` is defined.
- The array, reset clear, range check and read mux live in the top module.

## Test plan
- Pulse `rst_n` low, then sweep `addr` 0..31 with `we`=0 → `rd`=32'h00000000 at every address.
- Write addr 10 ← 32'h00000012, addr 5 ← 32'h0000F00F, addr 21 ← 32'h00000ABC on three consecutive edges, then sweep 0..31 → those three values, 0 elsewhere.
- `we`=0, `addr`=10, `wd`=32'hDEADBEEF for several edges → `rd` stays 32'h00000012. Then set `we`=1 → `rd`=32'hDEADBEEF immediately after the edge.
- Write `addr`=DEPTH (64) with `wd`=32'h55AA55AA → `rd` at 64 is 0 and addr 0 is unchanged (no wrap).
- Byte enables (`DATA_MEM_BYTE_EN` defined): addr 3 holds 32'h11223344. Write `wd`=32'hAABBCCDD with `be`=4'b0001 → 32'h112233DD. Then write with `be`=4'b1010 → 32'hAA22CCDD.
- Assert `rst_n` low between clock edges after the writes → `rd` reads 0 at addresses 5, 10 and 21 before the next edge.
